// File: rtl/biriscv_v_alu_ctrl.sv
// ============================================================================
// Module   : biriscv_v_alu_ctrl
// Brief    : Issue, stall and writeback controller for the vector ALU datapath,
//            with a per-register write scoreboard. Optional same-cycle
//            scoreboard bypass is enabled by defining V_ALU_SB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module biriscv_v_alu_ctrl #(
    parameter int ALU_LATENCY = 2,   // 1..4
    parameter int NUM_VREGS   = 32   // 1..32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    input  logic [31:0]          issue_opcode_i,
    input  logic [4:0]           issue_vd_idx_i,
    input  logic [4:0]           issue_va_idx_i,
    input  logic [4:0]           issue_vb_idx_i,
    input  logic                 issue_uses_vb_i,
    input  logic                 issue_masked_i,
    output logic                 issue_ready_o,
    input  logic                 flush_i,
    output logic                 alu_valid_o,
    output logic [31:0]          alu_opcode_o,
    output logic                 hold_o,
    output logic                 wb_valid_o,
    output logic [4:0]           wb_vd_idx_o,
    input  logic                 wb_ready_i,
    output logic [NUM_VREGS-1:0] sb_busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int c_LAST = ALU_LATENCY;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_LAST:0]        r_vld;
    logic [4:0]             r_vd [0:c_LAST];
    logic [31:0]            r_opcode;
    logic [NUM_VREGS-1:0]   r_sb;

    logic                   w_stall;
    logic                   w_wb_hs;
    logic                   w_hazard;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_pipe_busy;
    logic [NUM_VREGS-1:0]   w_clr_mask;
    logic [NUM_VREGS-1:0]   w_set_mask;
    logic [NUM_VREGS-1:0]   w_sb_chk;

    assign w_stall     = r_vld[c_LAST] && !wb_ready_i;
    assign w_wb_hs     = r_vld[c_LAST] && wb_ready_i;
    assign w_pipe_busy = |r_vld[c_LAST-1:0];

    always_comb begin
        w_clr_mask = '0;
        for (int n = 0; n < NUM_VREGS; n++) begin
            w_clr_mask[n] = w_wb_hs && (r_vd[c_LAST] == 5'(n));
        end
    end

`ifdef V_ALU_SB_BYPASS_EN
    // A register retiring this cycle is already safe to read or rewrite.
    assign w_sb_chk = r_sb & ~w_clr_mask;
`else
    assign w_sb_chk = r_sb;
`endif

    always_comb begin
        w_hazard = 1'b0;
        for (int n = 0; n < NUM_VREGS; n++) begin
            if (w_sb_chk[n]) begin
                if (issue_va_idx_i == 5'(n))                     w_hazard = 1'b1;
                if (issue_uses_vb_i && issue_vb_idx_i == 5'(n))  w_hazard = 1'b1;
                if (issue_vd_idx_i == 5'(n))                     w_hazard = 1'b1;
                if (issue_masked_i && n == 0)                    w_hazard = 1'b1;
            end
        end
    end

    // Gating with rst_ni keeps the handshake closed while reset is asserted.
    assign w_ready  = rst_ni && !w_stall && !w_hazard && !flush_i;
    assign w_accept = issue_valid_i && w_ready;

    always_comb begin
        w_set_mask = '0;
        for (int n = 0; n < NUM_VREGS; n++) begin
            w_set_mask[n] = w_accept && (issue_vd_idx_i == 5'(n));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld    <= '0;
            r_opcode <= '0;
            for (int i = 0; i <= c_LAST; i++) begin
                r_vd[i] <= '0;
            end
        end else if (flush_i) begin
            r_vld <= '0;
        end else if (!w_stall) begin
            r_vld   <= {r_vld[c_LAST-1:0], w_accept};
            r_vd[0] <= issue_vd_idx_i;
            for (int i = 1; i <= c_LAST; i++) begin
                r_vd[i] <= r_vd[i-1];
            end
            if (w_accept) begin
                r_opcode <= issue_opcode_i;
            end
        end
    end

    // Set is applied after clear so a same-index accept keeps the bit busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sb <= '0;
        end else if (flush_i) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_stall)                          w_state_nxt = ST_STALL;
                else if (!w_accept && !w_pipe_busy)   w_state_nxt = ST_IDLE;
            end
            ST_STALL: begin
                if (wb_ready_i) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush_i) w_state_nxt = ST_IDLE;
    end

    assign issue_ready_o = w_ready;
    assign alu_valid_o   = r_vld[0];
    assign alu_opcode_o  = r_opcode;
    assign hold_o        = w_stall;
    assign wb_valid_o    = r_vld[c_LAST];
    assign wb_vd_idx_o   = r_vd[c_LAST];
    assign sb_busy_o     = r_sb;

endmodule

`default_nettype wire

// File: tb/tb_biriscv_v_alu_ctrl.sv
// ============================================================================
// Module   : tb_biriscv_v_alu_ctrl
// Brief    : Directed self-checking bench for biriscv_v_alu_ctrl (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_biriscv_v_alu_ctrl;

`ifdef V_ALU_SB_BYPASS_EN
    localparam logic [31:0] c_BYP = 32'd1;
`else
    localparam logic [31:0] c_BYP = 32'd0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [31:0] issue_opcode_i = '0;
    logic [4:0]  issue_vd_idx_i = '0;
    logic [4:0]  issue_va_idx_i = '0;
    logic [4:0]  issue_vb_idx_i = '0;
    logic        issue_uses_vb_i = 1'b0;
    logic        issue_masked_i = 1'b0;
    logic        issue_ready_o;
    logic        flush_i = 1'b0;
    logic        alu_valid_o;
    logic [31:0] alu_opcode_o;
    logic        hold_o;
    logic        wb_valid_o;
    logic [4:0]  wb_vd_idx_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] sb_busy_o;

    int checks   = 0;
    int failures = 0;

    biriscv_v_alu_ctrl #(
        .ALU_LATENCY (2),
        .NUM_VREGS   (32)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .issue_valid_i   (issue_valid_i),
        .issue_opcode_i  (issue_opcode_i),
        .issue_vd_idx_i  (issue_vd_idx_i),
        .issue_va_idx_i  (issue_va_idx_i),
        .issue_vb_idx_i  (issue_vb_idx_i),
        .issue_uses_vb_i (issue_uses_vb_i),
        .issue_masked_i  (issue_masked_i),
        .issue_ready_o   (issue_ready_o),
        .flush_i         (flush_i),
        .alu_valid_o     (alu_valid_o),
        .alu_opcode_o    (alu_opcode_o),
        .hold_o          (hold_o),
        .wb_valid_o      (wb_valid_o),
        .wb_vd_idx_o     (wb_vd_idx_o),
        .wb_ready_i      (wb_ready_i),
        .sb_busy_o       (sb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [4:0] vd, input logic [4:0] va,
                          input logic [4:0] vb, input logic uvb, input logic msk,
                          input logic [31:0] opc);
        issue_valid_i   = v;
        issue_vd_idx_i  = vd;
        issue_va_idx_i  = va;
        issue_vb_idx_i  = vb;
        issue_uses_vb_i = uvb;
        issue_masked_i  = msk;
        issue_opcode_i  = opc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", {31'd0, issue_ready_o}, 0);
        check("rst_alu",   {31'd0, alu_valid_o}, 0);
        check("rst_wb",    {31'd0, wb_valid_o}, 0);
        check("rst_hold",  {31'd0, hold_o}, 0);
        check("rst_wbvd",  {27'd0, wb_vd_idx_o}, 0);
        check("rst_sb",    sb_busy_o, 0);
        check("rst_opc",   alu_opcode_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rel_ready", {31'd0, issue_ready_o}, 1);
        tick();

        // Single vadd.vv vd=3 va=1 vb=2
        set_op(1, 3, 1, 2, 1, 0, 32'h0020_8157);
        #1;
        check("t1_ready", {31'd0, issue_ready_o}, 1);
        check("t1_alu_pre", {31'd0, alu_valid_o}, 0);
        tick();
        set_op(0, 10, 1, 3, 1, 0, 32'h0);
        #1;
        check("t1_alu_t1", {31'd0, alu_valid_o}, 1);
        check("t1_opc", alu_opcode_o, 32'h0020_8157);
        check("t1_sb_t1", sb_busy_o, 32'h8);
        check("t1_wb_t1", {31'd0, wb_valid_o}, 0);
        check("t1_raw_vb", {31'd0, issue_ready_o}, 0);
        issue_uses_vb_i = 1'b0;
        #1;
        check("t1_vb_unused", {31'd0, issue_ready_o}, 1);
        issue_vd_idx_i = 5'd3;
        #1;
        check("t1_waw", {31'd0, issue_ready_o}, 0);
        tick();
        check("t1_alu_t2", {31'd0, alu_valid_o}, 0);
        check("t1_wb_t2", {31'd0, wb_valid_o}, 0);
        check("t1_sb_t2", sb_busy_o, 32'h8);
        tick();
        check("t1_wb_t3", {31'd0, wb_valid_o}, 1);
        check("t1_wbvd_t3", {27'd0, wb_vd_idx_o}, 3);
        check("t1_sb_t3", sb_busy_o, 32'h8);
        tick();
        check("t1_wb_t4", {31'd0, wb_valid_o}, 0);
        check("t1_sb_t4", sb_busy_o, 0);

        // RAW on v5
        set_op(1, 5, 1, 0, 0, 0, 32'h11);
        #1;
        check("t2_ready", {31'd0, issue_ready_o}, 1);
        tick();
        set_op(0, 8, 5, 0, 0, 0, 32'h0);
        #1;
        check("t2_raw_c1", {31'd0, issue_ready_o}, 0);
        tick();
        check("t2_raw_c2", {31'd0, issue_ready_o}, 0);
        tick();
        check("t2_wb", {31'd0, wb_valid_o}, 1);
        check("t2_wbvd", {27'd0, wb_vd_idx_o}, 5);
        check("t2_bypass", {31'd0, issue_ready_o}, c_BYP);
        tick();
        check("t2_after", {31'd0, issue_ready_o}, 1);
        check("t2_sb", sb_busy_o, 0);

        // Three independent ops, writeback stalled for 2 cycles
        set_op(1, 4, 20, 21, 1, 0, 32'hA4);
        #1;
        check("t3_rdy4", {31'd0, issue_ready_o}, 1);
        tick();
        set_op(1, 6, 22, 23, 1, 0, 32'hA6);
        #1;
        check("t3_rdy6", {31'd0, issue_ready_o}, 1);
        tick();
        set_op(1, 7, 24, 25, 1, 0, 32'hA7);
        #1;
        check("t3_rdy7", {31'd0, issue_ready_o}, 1);
        tick();
        set_op(0, 26, 27, 28, 1, 0, 32'h0);
        wb_ready_i = 1'b0;
        #1;
        check("t3_s1_wb", {31'd0, wb_valid_o}, 1);
        check("t3_s1_wbvd", {27'd0, wb_vd_idx_o}, 4);
        check("t3_s1_hold", {31'd0, hold_o}, 1);
        check("t3_s1_ready", {31'd0, issue_ready_o}, 0);
        tick();
        check("t3_s2_wbvd", {27'd0, wb_vd_idx_o}, 4);
        check("t3_s2_hold", {31'd0, hold_o}, 1);
        check("t3_s2_ready", {31'd0, issue_ready_o}, 0);
        check("t3_s2_alu", {31'd0, alu_valid_o}, 1);
        check("t3_s2_opc", alu_opcode_o, 32'hA7);
        tick();
        check("t3_frozen_wbvd", {27'd0, wb_vd_idx_o}, 4);
        wb_ready_i = 1'b1;
        #1;
        check("t3_go_hold", {31'd0, hold_o}, 0);
        check("t3_go_ready", {31'd0, issue_ready_o}, 1);
        tick();
        check("t3_wb6_v", {31'd0, wb_valid_o}, 1);
        check("t3_wb6", {27'd0, wb_vd_idx_o}, 6);
        tick();
        check("t3_wb7_v", {31'd0, wb_valid_o}, 1);
        check("t3_wb7", {27'd0, wb_vd_idx_o}, 7);
        tick();
        check("t3_done_wb", {31'd0, wb_valid_o}, 0);
        check("t3_done_sb", sb_busy_o, 0);

        // Masked op waits on v0
        set_op(1, 0, 1, 2, 0, 0, 32'hB0);
        #1;
        check("t4_ready", {31'd0, issue_ready_o}, 1);
        tick();
        set_op(0, 9, 2, 3, 0, 1, 32'h0);
        #1;
        check("t4_mask_blk", {31'd0, issue_ready_o}, 0);
        issue_masked_i = 1'b0;
        #1;
        check("t4_unmasked", {31'd0, issue_ready_o}, 1);
        issue_masked_i = 1'b1;
        tick();
        check("t4_mask_blk2", {31'd0, issue_ready_o}, 0);
        tick();
        check("t4_wb_v0", {31'd0, wb_valid_o}, 1);
        check("t4_wbvd0", {27'd0, wb_vd_idx_o}, 0);
        check("t4_bypass", {31'd0, issue_ready_o}, c_BYP);
        tick();
        check("t4_after", {31'd0, issue_ready_o}, 1);
        check("t4_sb", sb_busy_o, 0);

        // Flush with three ops in flight, coinciding with a wb handshake
        set_op(1, 12, 1, 2, 1, 0, 32'hC2);
        tick();
        set_op(1, 13, 1, 2, 1, 0, 32'hC3);
        tick();
        set_op(1, 14, 1, 2, 1, 0, 32'hC4);
        tick();
        set_op(0, 20, 21, 22, 1, 0, 32'h0);
        check("t5_sb_full", sb_busy_o, 32'h0000_7000);
        flush_i = 1'b1;
        #1;
        check("t5_wb", {31'd0, wb_valid_o}, 1);
        check("t5_wbvd", {27'd0, wb_vd_idx_o}, 12);
        check("t5_ready_fl", {31'd0, issue_ready_o}, 0);
        tick();
        flush_i = 1'b0;
        #1;
        check("t5_alu", {31'd0, alu_valid_o}, 0);
        check("t5_wb_post", {31'd0, wb_valid_o}, 0);
        check("t5_sb", sb_busy_o, 0);
        check("t5_ready", {31'd0, issue_ready_o}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_wb", {31'd0, wb_valid_o}, 0);
        end

        // Asynchronous reset mid-stream
        set_op(1, 15, 1, 2, 1, 0, 32'hC5);
        tick();
        set_op(1, 16, 1, 2, 1, 0, 32'hC6);
        tick();
        set_op(0, 20, 21, 22, 1, 0, 32'h0);
        tick();
        check("t6_pre_wb", {31'd0, wb_valid_o}, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_wb", {31'd0, wb_valid_o}, 0);
        check("t6_alu", {31'd0, alu_valid_o}, 0);
        check("t6_hold", {31'd0, hold_o}, 0);
        check("t6_ready", {31'd0, issue_ready_o}, 0);
        check("t6_sb", sb_busy_o, 0);
        check("t6_wbvd", {27'd0, wb_vd_idx_o}, 0);
        check("t6_opc", alu_opcode_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("t6_rel_ready", {31'd0, issue_ready_o}, 1);
        check("t6_rel_wb", {31'd0, wb_valid_o}, 0);
        tick();
        check("t6_rel_wb2", {31'd0, wb_valid_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/biriscv_v_alu_ctrl.md
BIRISCV_V_ALU_CTRL -- requirements
Module: biriscv_v_alu_ctrl

Interface
REQ-001 Parameter ALU_LATENCY, default 2: datapath stages from ALU issue to result; legal range 1..4.
REQ-002 Parameter NUM_VREGS, default 32: number of architectural vector registers tracked.
REQ-003 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 issue_valid_i  input  1  an instruction is offered.
REQ-006 issue_opcode_i  input  32  opcode of the offered vector ALU instruction.
REQ-007 issue_vd_idx_i / issue_va_idx_i / issue_vb_idx_i  input  5 each  destination and source register indices.
REQ-008 issue_uses_vb_i  input  1  the instruction reads vb (.vv form).
REQ-009 issue_masked_i  input  1  vm=0; the instruction reads v0.
REQ-010 issue_ready_o  output  1  the instruction is accepted this cycle.
REQ-011 flush_i  input  1  kills all ops that have not yet written back.
REQ-012 alu_valid_o  output  1  drives the vector ALU datapath opcode_valid_i.
REQ-013 alu_opcode_o  output  32  registered opcode presented to the datapath.
REQ-014 hold_o  output  1  freezes the datapath pipeline.
REQ-015 wb_valid_o  output  1  a result is ready for the vector register file.
REQ-016 wb_vd_idx_o  output  5  destination index of that result.
REQ-017 wb_ready_i  input  1  the register file accepts the result.
REQ-018 sb_busy_o  output  NUM_VREGS  scoreboard; bit n set while vn has a pending write.

Function
REQ-019 Track ops in stage valid bits s[0..ALU_LATENCY], each with vd; alu_valid_o=s[0].valid; wb_valid_o=s[ALU_LATENCY].valid.
REQ-020 Accept on issue_valid_i && issue_ready_o at edge T: alu_valid_o high in cycle T+1, wb_valid_o high in T+1+ALU_LATENCY when no stall occurs.
REQ-021 Stall = wb_valid_o && !wb_ready_i: hold_o=1; all stages and alu_opcode_o frozen; issue_ready_o=0.
REQ-022 Hazard = sb_busy_o[va] | (issue_uses_vb_i & sb_busy_o[vb]) | sb_busy_o[vd] | (issue_masked_i & sb_busy_o[0]).
REQ-023 issue_ready_o = !stall && !hazard && !flush_i; it is combinational and does not depend on issue_valid_i.
REQ-024 On accept, set sb_busy_o[vd]; on a wb handshake, clear sb_busy_o[wb_vd_idx_o]; if both hit the same index in one cycle, the set wins.
REQ-025 Controller FSM: IDLE (no stage valid) -> RUN on accept; RUN -> STALL on stall; STALL -> RUN on wb_ready_i; RUN -> IDLE when the last valid stage drains with no accept; any state -> IDLE on flush_i.
REQ-026 In-flight count never exceeds ALU_LATENCY+1, and back-to-back independent ops sustain 1 op/cycle.
REQ-027 flush_i (synchronous, at the next edge) clears all stage valids and sb_busy_o, and takes priority over accept and wb.
REQ-028 A wb handshake coinciding with flush_i completes normally: the register file write happens, and the flush still clears state.
REQ-029 No op accepted yet: wb_valid_o=0 and alu_valid_o=0, and all register indices are ignored.

Reset
REQ-030 Asynchronous assertion of rst_ni low clears all stage valids, sb_busy_o=0, alu_opcode_o=0, and sets the FSM to IDLE.
REQ-031 During reset: issue_ready_o=0, alu_valid_o=0, wb_valid_o=0, hold_o=0, wb_vd_idx_o=0.
REQ-032 Reset mid-operation discards in-flight ops without generating any writeback.

Configuration
REQ-033 Macro V_ALU_SB_BYPASS_EN is defined: a scoreboard bit being cleared by a wb handshake in the same cycle counts as not busy for the hazard check, so a dependent op issues in that cycle.
REQ-034 Macro V_ALU_SB_BYPASS_EN is undefined: a dependent op issues no earlier than the cycle after the wb handshake.

Verification
REQ-035 Reset with rst_ni=0 mid-stream -> all outputs 0 immediately, sb_busy_o=0; issue_ready_o=1 after release.
REQ-036 Single vadd.vv (vd=3, va=1, vb=2) accepted at T, wb_ready_i=1 -> alu_valid_o at T+1; wb_valid_o with wb_vd_idx_o=3 at T+3; sb_busy_o[3] set T+1..T+3 and cleared after.
REQ-037 Op writes v5, then op reads va=5 -> issue_ready_o=0 until wb of v5; with the bypass macro it issues in the wb cycle, without it one cycle later.
REQ-038 Three independent ops back-to-back, wb_ready_i=0 for 2 cycles at first wb -> hold_o=1 and issue_ready_o=0 for 2 cycles; results appear in order vd=4,6,7 with no loss.
REQ-039 Masked op (issue_masked_i=1) while v0 is pending -> blocked until v0 writes back.
REQ-040 flush_i with 3 ops in flight -> next cycle all valids=0, sb_busy_o=0, FSM IDLE, and no further wb_valid_o.
